run_checker: RTL and testbench
==============================

RUN_CHECKER -- requirements
Module: run_checker

Interface
REQ-001 SHALL have parameter DW, default 32: data word width.
REQ-002 SHALL have parameter AW, default 32: PC and word-index width.
REQ-003 SHALL have parameter END_PC, default 32'h58: PC value that marks program completion.
REQ-004 SHALL have parameter BASE_IDX, default 16: first data-memory word index to check.
REQ-005 SHALL have parameter NWORDS, default 15, range 1..255: number of words checked.
REQ-006 SHALL have parameter MODE, default MODE_FIB: MODE_FIB uses an internal generator, MODE_EXT uses the external expected port.
REQ-007 SHALL have parameters FIB_S0 and FIB_S1, defaults 0 and 1: first two expected words in MODE_FIB.
REQ-008 SHALL have parameter MAX_CYCLES, default 100000: watchdog limit.
REQ-009 clk  in  1  single clock; all state updates on rising edge.
REQ-010 reset  in  1  asynchronous, active-low reset.
REQ-011 pc  in  AW  processor program counter.
REQ-012 rd_en  out  1  data-memory read strobe.
REQ-013 rd_addr  out  AW  data-memory word index.
REQ-014 rd_data  in  DW  read data, valid one cycle after rd_en.
REQ-015 exp_addr  out  AW  expected-value index 0..NWORDS-1; same timing as rd_addr.
REQ-016 exp_data  in  DW  expected value; same latency as rd_data; ignored in MODE_FIB.
REQ-017 done  out  1  check finished (pass, fail or timeout); sticky.
REQ-018 pass  out  1  all NWORDS words matched; meaningful only when done=1.
REQ-019 timeout  out  1  watchdog expired before END_PC was reached.
REQ-020 fail_count  out  8  number of mismatched words.
REQ-021 first_fail  out  AW  offset (0-based) of the first mismatch; 0 when fail_count=0.
REQ-022 cycles  out  32  cycles from reset release to END_PC detection; saturates at all-ones.

Function
REQ-023 SHALL implement the state machine WAIT -> SCAN -> DRAIN -> DONE, with WAIT -> TOUT on watchdog expiry; DONE and TOUT SHALL hold until reset.
REQ-024 In WAIT, cycles SHALL increment every clock and the block SHALL compare pc against END_PC every clock.
REQ-025 If pc==END_PC is sampled at edge k, the block SHALL enter SCAN at edge k and freeze cycles.
REQ-026 In SCAN, rd_en SHALL be 1, and rd_addr SHALL be BASE_IDX+i and exp_addr SHALL be i in the i-th SCAN cycle, for i=0..NWORDS-1, with one read issued per cycle.
REQ-027 Each returned word SHALL be compared one cycle after issue; the block SHALL enter DRAIN after the last issue; and DONE SHALL be entered at edge k+NWORDS+1.
REQ-028 On mismatch, fail_count SHALL increment, saturating at 255, and the first mismatch offset SHALL be latched into first_fail.
REQ-029 On entry to DONE, done SHALL be 1 and pass SHALL be 1 iff fail_count=0.
REQ-030 In MODE_FIB, the expected value SHALL be e0=FIB_S0, e1=FIB_S1, en=e(n-1)+e(n-2) mod 2^DW (wrap, no saturation), advanced in lockstep with compares.
REQ-031 If cycles reaches MAX_CYCLES in WAIT, the block SHALL enter TOUT with done=1, timeout=1 and pass=0.
REQ-032 If END_PC and watchdog expiry occur on the same edge, END_PC SHALL win.
REQ-033 pc==END_PC outside WAIT SHALL be ignored.
REQ-034 rd_en SHALL be 0 in every state except SCAN.

Reset
REQ-035 While reset=0: state=WAIT; rd_en, done, pass, timeout, fail_count, first_fail, cycles, rd_addr and exp_addr =0; generator reloaded with FIB_S0/FIB_S1.
REQ-036 Assertion mid-SCAN or mid-DRAIN SHALL abort immediately, and in-flight read data SHALL be discarded.

Structure
REQ-037 Package run_checker_pkg SHALL hold the state enum (WAIT, SCAN, DRAIN, DONE, TOUT) and the MODE_FIB/MODE_EXT constants.
REQ-038 The expected-value recurrence SHALL live in sub-module fib_gen (ports clk, reset, load, step, value) and be instantiated only when MODE=MODE_FIB.

Verification
REQ-039 Fib pass: memory words 16..30 = 0,1,1,2,...,377; pc steps to 32'h58 at cycle 200 -> done=1, pass=1, fail_count=0, cycles=200, rd_en high exactly 15 cycles.
REQ-040 Single corruption: word 21 = 0 instead of 5 -> pass=0, fail_count=1, first_fail=5.
REQ-041 Timeout: MAX_CYCLES=50, pc never reaches 32'h58 -> timeout=1, done=1, pass=0 at cycle 50, rd_en never asserted.
REQ-042 Tie: pc==32'h58 on the exact expiry cycle -> SCAN entered, timeout stays 0.
REQ-043 MODE_EXT: exp ROM = 8'hAA repeated, NWORDS=4, memory matches except offset 3 -> fail_count=1, first_fail=3; a second pc==32'h58 after done -> no new reads.
REQ-044 Reset pulse at SCAN offset 7 -> all outputs 0 next edge; rerun completes normally with cycles counted from the new reset release.

Source files
------------

// File: rtl/run_checker_pkg.sv
// Shared types for the post-run memory checker: FSM state encoding and reference-source selection.
// Latency/backpressure: n/a (types and constants only).
package run_checker_pkg;

    typedef enum logic [2:0] {
        WAIT,
        SCAN,
        DRAIN,
        DONE,
        TOUT
    } state_t;

    localparam int MODE_FIB = 0;
    localparam int MODE_EXT = 1;

    localparam logic [7:0] FCNT_MAX = 8'hFF;

endpackage

// File: rtl/fib_gen.sv
// Fibonacci expected-value generator; value shows the current term, step advances one term (mod 2^DW).
// Latency: new term visible one cycle after step; load has priority over step; no backpressure.
module fib_gen #(
    parameter int            DW = 32,
    parameter logic [DW-1:0] S0 = DW'(0),
    parameter logic [DW-1:0] S1 = DW'(1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          step,
    output logic [DW-1:0] value
);

    logic [DW-1:0] r_cur;
    logic [DW-1:0] r_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cur <= S0;
            r_nxt <= S1;
        end else if (load) begin
            r_cur <= S0;
            r_nxt <= S1;
        end else if (step) begin
            r_cur <= r_nxt;
            r_nxt <= r_cur + r_nxt;
        end
    end

    assign value = r_cur;

endmodule

// File: rtl/run_checker.sv
// Post-run checker: waits for END_PC, reads NWORDS words and compares them with a Fibonacci or external reference.
// Latency: DONE NWORDS+1 cycles after END_PC is sampled; no backpressure, one read issued per SCAN cycle.
module run_checker
    import run_checker_pkg::*;
#(
    parameter int            DW         = 32,
    parameter int            AW         = 32,
    parameter logic [AW-1:0] END_PC     = AW'(32'h58),
    parameter int            BASE_IDX   = 16,
    parameter int            NWORDS     = 15,
    parameter int            MODE       = MODE_FIB,
    parameter logic [DW-1:0] FIB_S0     = DW'(0),
    parameter logic [DW-1:0] FIB_S1     = DW'(1),
    parameter int            MAX_CYCLES = 100000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] pc,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic [AW-1:0] exp_addr,
    input  logic [DW-1:0] exp_data,
    output logic          done,
    output logic          pass,
    output logic          timeout,
    output logic [7:0]    fail_count,
    output logic [AW-1:0] first_fail,
    output logic [31:0]   cycles
);

    localparam logic [7:0]  LAST_IDX = 8'(NWORDS - 1);
    localparam logic [31:0] WD_LIMIT = 32'(MAX_CYCLES);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [7:0]    r_idx;
    logic          r_cmp_vld;
    logic [7:0]    r_cmp_off;
    logic [7:0]    r_fail_cnt;
    logic [AW-1:0] r_first_fail;
    logic [31:0]   r_cycles;
    logic [31:0]   w_cyc_inc;
    logic          w_end_hit;
    logic          w_wd_exp;
    logic          w_mismatch;
    logic [DW-1:0] w_expected;

    assign w_cyc_inc  = (r_cycles == '1) ? r_cycles : r_cycles + 32'd1;
    assign w_end_hit  = (pc == END_PC);
    assign w_wd_exp   = (w_cyc_inc >= WD_LIMIT);
    assign w_mismatch = r_cmp_vld && (rd_data != w_expected);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= WAIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // END_PC is checked before the watchdog so a same-edge tie goes to SCAN.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            WAIT: begin
                if (w_end_hit) begin
                    w_state_nxt = SCAN;
                end else if (w_wd_exp) begin
                    w_state_nxt = TOUT;
                end
            end
            SCAN: begin
                if (r_idx == LAST_IDX) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN:   w_state_nxt = DONE;
            default: w_state_nxt = r_state;
        endcase
    end

    always_comb begin
        rd_en    = 1'b0;
        rd_addr  = '0;
        exp_addr = '0;
        done     = 1'b0;
        pass     = 1'b0;
        timeout  = 1'b0;
        unique case (r_state)
            SCAN: begin
                rd_en    = 1'b1;
                rd_addr  = AW'(BASE_IDX) + AW'(r_idx);
                exp_addr = AW'(r_idx);
            end
            DONE: begin
                done = 1'b1;
                pass = (r_fail_cnt == '0);
            end
            TOUT: begin
                done    = 1'b1;
                timeout = 1'b1;
            end
            default: begin
                rd_en = 1'b0;
            end
        endcase
    end

    // Read data returns one cycle after issue, so the compare pipeline trails the issue index by one stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idx        <= '0;
            r_cmp_vld    <= 1'b0;
            r_cmp_off    <= '0;
            r_fail_cnt   <= '0;
            r_first_fail <= '0;
            r_cycles     <= '0;
        end else begin
            if (r_state == WAIT && !w_end_hit) begin
                r_cycles <= w_cyc_inc;
            end
            r_idx     <= (r_state == SCAN) ? r_idx + 8'd1 : '0;
            r_cmp_vld <= (r_state == SCAN);
            r_cmp_off <= r_idx;
            if (w_mismatch) begin
                if (r_fail_cnt != FCNT_MAX) begin
                    r_fail_cnt <= r_fail_cnt + 8'd1;
                end
                if (r_fail_cnt == '0) begin
                    r_first_fail <= AW'(r_cmp_off);
                end
            end
        end
    end

    assign fail_count = r_fail_cnt;
    assign first_fail = r_first_fail;
    assign cycles     = r_cycles;

    generate
        if (MODE == MODE_FIB) begin : g_fib
            logic [DW-1:0] w_fib_val;
            logic          w_unused_exp;

            fib_gen #(
                .DW (DW),
                .S0 (FIB_S0),
                .S1 (FIB_S1)
            ) u_fib_gen (
                .clk   (clk),
                .reset (reset),
                .load  (r_state == WAIT),
                .step  (r_cmp_vld),
                .value (w_fib_val)
            );

            assign w_expected   = w_fib_val;
            assign w_unused_exp = ^exp_data;
        end else begin : g_ext
            assign w_expected = exp_data;
        end
    endgenerate

endmodule

// File: tb/tb_run_checker.sv
module tb_run_checker;
    import run_checker_pkg::*;

    localparam int          NW    = 15;
    localparam int          NWE   = 4;
    localparam int          BASE  = 16;
    localparam logic [31:0] ENDPC = 32'h58;
    localparam logic [31:0] TS0   = 32'hFFFF_FFF0;
    localparam logic [31:0] TS1   = 32'h0000_0020;

    int n_tests = 0;
    int n_fail  = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // default Fibonacci instance
    logic        rst_f = 1'b0;
    logic [31:0] pc_f = '0;
    logic        rd_en_f, done_f, pass_f, tout_f;
    logic [31:0] rd_addr_f, exp_addr_f, ffirst_f, cyc_f;
    logic [31:0] rd_data_f = '0;
    logic [31:0] exp_data_f = '0;
    logic [7:0]  fcnt_f;

    // short-watchdog instance with wrapping seeds
    logic        rst_t = 1'b0;
    logic [31:0] pc_t = '0;
    logic        rd_en_t, done_t, pass_t, tout_t;
    logic [31:0] rd_addr_t, exp_addr_t, ffirst_t, cyc_t;
    logic [31:0] rd_data_t = '0;
    logic [31:0] exp_data_t = '0;
    logic [7:0]  fcnt_t;

    // external-reference instance
    logic        rst_e = 1'b0;
    logic [31:0] pc_e = '0;
    logic        rd_en_e, done_e, pass_e, tout_e;
    logic [31:0] rd_addr_e, exp_addr_e, ffirst_e, cyc_e;
    logic [7:0]  rd_data_e = '0;
    logic [7:0]  exp_data_e = '0;
    logic [7:0]  fcnt_e;

    run_checker u_fib (
        .clk(clk), .reset(rst_f), .pc(pc_f), .rd_en(rd_en_f), .rd_addr(rd_addr_f),
        .rd_data(rd_data_f), .exp_addr(exp_addr_f), .exp_data(exp_data_f), .done(done_f),
        .pass(pass_f), .timeout(tout_f), .fail_count(fcnt_f), .first_fail(ffirst_f), .cycles(cyc_f)
    );

    run_checker #(.MAX_CYCLES(50), .FIB_S0(TS0), .FIB_S1(TS1)) u_tout (
        .clk(clk), .reset(rst_t), .pc(pc_t), .rd_en(rd_en_t), .rd_addr(rd_addr_t),
        .rd_data(rd_data_t), .exp_addr(exp_addr_t), .exp_data(exp_data_t), .done(done_t),
        .pass(pass_t), .timeout(tout_t), .fail_count(fcnt_t), .first_fail(ffirst_t), .cycles(cyc_t)
    );

    run_checker #(.DW(8), .NWORDS(NWE), .MODE(MODE_EXT)) u_ext (
        .clk(clk), .reset(rst_e), .pc(pc_e), .rd_en(rd_en_e), .rd_addr(rd_addr_e),
        .rd_data(rd_data_e), .exp_addr(exp_addr_e), .exp_data(exp_data_e), .done(done_e),
        .pass(pass_e), .timeout(tout_e), .fail_count(fcnt_e), .first_fail(ffirst_e), .cycles(cyc_e)
    );

    logic [31:0] mem_f [0:63];
    logic [31:0] mem_t [0:63];
    logic [7:0]  mem_e [0:63];
    logic [31:0] alog_f [0:255];
    logic [31:0] elog_f [0:255];
    int rdn_f = 0;
    int rdn_t = 0;
    int rdn_e = 0;

    // Synchronous memories: data for a read issued in one cycle is presented in the next.
    always @(posedge clk) begin
        if (rd_en_f) begin
            rd_data_f            <= mem_f[rd_addr_f[5:0]];
            alog_f[rdn_f[7:0]]   <= rd_addr_f;
            elog_f[rdn_f[7:0]]   <= exp_addr_f;
            rdn_f                <= rdn_f + 1;
        end
        if (rd_en_t) begin
            rd_data_t <= mem_t[rd_addr_t[5:0]];
            rdn_t     <= rdn_t + 1;
        end
        if (rd_en_e) begin
            rd_data_e  <= mem_e[rd_addr_e[5:0]];
            exp_data_e <= 8'hAA;
            rdn_e      <= rdn_e + 1;
        end
    end

    function automatic logic [31:0] fibv(input logic [31:0] s0, input logic [31:0] s1, input int n);
        logic [31:0] a, b, c;
        a = s0;
        b = s1;
        for (int i = 0; i < n; i++) begin
            c = a + b;
            a = b;
            b = c;
        end
        return a;
    endfunction

    function automatic logic [31:0] rand_pc();
        logic [31:0] v;
        do v = $urandom; while (v == ENDPC);
        return v;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic fib_run(input string tag, input int t);
        int exp_cnt = 0;
        int exp_first = 0;
        bit seen = 0;
        int base;
        int bad = 0;
        for (int i = 0; i < NW; i++) begin
            if (mem_f[BASE + i] !== fibv(32'd0, 32'd1, i)) begin
                exp_cnt++;
                if (!seen) begin
                    exp_first = i;
                    seen = 1;
                end
            end
        end
        pc_f  = '0;
        rst_f = 1'b0;
        repeat (2) @(negedge clk);
        rst_f = 1'b1;
        base  = rdn_f;
        for (int i = 0; i < t; i++) begin
            pc_f = rand_pc();
            @(negedge clk);
        end
        pc_f = ENDPC;
        @(negedge clk);
        check({tag, "/scan0_rd_en"}, 64'(rd_en_f), 64'd1);
        check({tag, "/scan0_rd_addr"}, 64'(rd_addr_f), 64'(BASE));
        check({tag, "/scan0_exp_addr"}, 64'(exp_addr_f), 64'd0);
        check({tag, "/cycles_frozen"}, 64'(cyc_f), 64'(t));
        repeat (NW) @(negedge clk);
        check({tag, "/drain_done_rd_en"}, 64'({done_f, rd_en_f}), 64'd0);
        @(negedge clk);
        check({tag, "/done"}, 64'(done_f), 64'd1);
        check({tag, "/pass"}, 64'(pass_f), 64'(exp_cnt == 0));
        check({tag, "/fail_count"}, 64'(fcnt_f), 64'(exp_cnt));
        check({tag, "/first_fail"}, 64'(ffirst_f), 64'(exp_first));
        check({tag, "/cycles"}, 64'(cyc_f), 64'(t));
        check({tag, "/timeout"}, 64'(tout_f), 64'd0);
        check({tag, "/reads"}, 64'(rdn_f - base), 64'(NW));
        for (int i = 0; i < NW; i++) begin
            if (alog_f[8'(base + i)] !== 32'(BASE + i) || elog_f[8'(base + i)] !== 32'(i)) bad++;
        end
        check({tag, "/addr_seq"}, 64'(bad), 64'd0);
        pc_f = '0;
        @(negedge clk);
        pc_f = ENDPC;
        repeat (3) @(negedge clk);
        check({tag, "/no_rescan"}, 64'(rdn_f - base), 64'(NW));
        check({tag, "/done_sticky"}, 64'({done_f, pass_f}), 64'({1'b1, exp_cnt == 0}));
    endtask

    task automatic ext_run(input string tag, input logic [3:0] mask);
        int exp_cnt = 0;
        int exp_first = 0;
        bit seen = 0;
        int base;
        int t;
        for (int i = 0; i < NWE; i++) begin
            mem_e[BASE + i] = mask[i] ? (8'hAA ^ 8'($urandom_range(1, 255))) : 8'hAA;
            if (mask[i]) begin
                exp_cnt++;
                if (!seen) begin
                    exp_first = i;
                    seen = 1;
                end
            end
        end
        t     = $urandom_range(1, 30);
        pc_e  = '0;
        rst_e = 1'b0;
        repeat (2) @(negedge clk);
        rst_e = 1'b1;
        base  = rdn_e;
        for (int i = 0; i < t; i++) begin
            pc_e = rand_pc();
            @(negedge clk);
        end
        pc_e = ENDPC;
        @(negedge clk);
        check({tag, "/scan0_rd_en"}, 64'(rd_en_e), 64'd1);
        repeat (NWE) @(negedge clk);
        check({tag, "/not_done_yet"}, 64'(done_e), 64'd0);
        @(negedge clk);
        check({tag, "/done_pass"}, 64'({done_e, pass_e}), 64'({1'b1, exp_cnt == 0}));
        check({tag, "/fail_count"}, 64'(fcnt_e), 64'(exp_cnt));
        check({tag, "/first_fail"}, 64'(ffirst_e), 64'(exp_first));
        check({tag, "/reads"}, 64'(rdn_e - base), 64'(NWE));
        pc_e = '0;
        @(negedge clk);
        pc_e = ENDPC;
        repeat (4) @(negedge clk);
        check({tag, "/no_rescan"}, 64'(rdn_e - base), 64'(NWE));
    endtask

    initial begin
        int t;
        int base;
        for (int i = 0; i < 64; i++) begin
            mem_f[i] = $urandom;
            mem_t[i] = $urandom;
            mem_e[i] = 8'($urandom);
        end
        for (int i = 0; i < NW; i++) begin
            mem_t[BASE + i] = fibv(TS0, TS1, i);
        end

        // Reset state
        repeat (2) @(negedge clk);
        check("reset/flags", 64'({rd_en_f, done_f, pass_f, tout_f, fcnt_f}), 64'd0);
        check("reset/cycles", 64'(cyc_f), 64'd0);
        check("reset/addrs", 64'({rd_addr_f, exp_addr_f}), 64'd0);

        // Clean Fibonacci image, END_PC after 200 cycles
        for (int i = 0; i < NW; i++) mem_f[BASE + i] = fibv(32'd0, 32'd1, i);
        fib_run("fib_clean", 200);

        // Word 21 (offset 5) zeroed
        mem_f[BASE + 5] = 32'd0;
        fib_run("fib_word21", $urandom_range(1, 60));

        // END_PC on the very first edge after release
        for (int i = 0; i < NW; i++) mem_f[BASE + i] = fibv(32'd0, 32'd1, i);
        fib_run("fib_t0", 0);

        // Randomized corruption patterns
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < NW; i++) begin
                mem_f[BASE + i] = fibv(32'd0, 32'd1, i);
                if ($urandom_range(0, 3) == 0) mem_f[BASE + i] = mem_f[BASE + i] ^ ($urandom | 32'd1);
            end
            fib_run($sformatf("fib_rand%0d", r), $urandom_range(1, 300));
        end

        // Reset pulse in the middle of SCAN, offset 5 already mismatched
        for (int i = 0; i < NW; i++) mem_f[BASE + i] = fibv(32'd0, 32'd1, i);
        mem_f[BASE + 5] = 32'hDEAD_BEEF;
        pc_f  = '0;
        rst_f = 1'b0;
        repeat (2) @(negedge clk);
        rst_f = 1'b1;
        t = $urandom_range(5, 40);
        for (int i = 0; i < t; i++) begin
            pc_f = rand_pc();
            @(negedge clk);
        end
        pc_f = ENDPC;
        @(negedge clk);
        repeat (7) @(negedge clk);
        check("abort/pre_rd_addr", 64'(rd_addr_f), 64'(BASE + 7));
        check("abort/pre_fail_count", 64'(fcnt_f), 64'd1);
        rst_f = 1'b0;
        @(negedge clk);
        check("abort/flags", 64'({rd_en_f, done_f, pass_f, tout_f, fcnt_f}), 64'd0);
        check("abort/first_fail", 64'(ffirst_f), 64'd0);
        check("abort/cycles", 64'(cyc_f), 64'd0);
        check("abort/addrs", 64'({rd_addr_f, exp_addr_f}), 64'd0);
        mem_f[BASE + 5] = fibv(32'd0, 32'd1, 5);
        fib_run("abort_rerun", $urandom_range(1, 80));

        // Watchdog expiry with MAX_CYCLES=50
        pc_t  = '0;
        rst_t = 1'b0;
        repeat (2) @(negedge clk);
        rst_t = 1'b1;
        base  = rdn_t;
        for (int i = 0; i < 49; i++) begin
            pc_t = rand_pc();
            @(negedge clk);
        end
        check("tout/before_flags", 64'({done_t, tout_t}), 64'd0);
        check("tout/before_cycles", 64'(cyc_t), 64'd49);
        pc_t = rand_pc();
        @(negedge clk);
        check("tout/flags", 64'({done_t, tout_t, pass_t}), 64'b110);
        check("tout/cycles", 64'(cyc_t), 64'd50);
        pc_t = ENDPC;
        repeat (5) @(negedge clk);
        check("tout/no_reads", 64'(rdn_t - base), 64'd0);
        check("tout/sticky", 64'({done_t, tout_t, rd_en_t}), 64'b110);

        // END_PC on the expiry edge wins; seeds wrap mod 2^32
        pc_t  = '0;
        rst_t = 1'b0;
        repeat (2) @(negedge clk);
        rst_t = 1'b1;
        base  = rdn_t;
        for (int i = 0; i < 49; i++) begin
            pc_t = rand_pc();
            @(negedge clk);
        end
        pc_t = ENDPC;
        @(negedge clk);
        check("tie/scan", 64'({tout_t, rd_en_t, done_t}), 64'b010);
        check("tie/cycles", 64'(cyc_t), 64'd49);
        repeat (NW + 1) @(negedge clk);
        check("tie/done_pass", 64'({done_t, pass_t, tout_t}), 64'b110);
        check("tie/fail_count", 64'(fcnt_t), 64'd0);
        check("tie/reads", 64'(rdn_t - base), 64'(NW));

        // External reference
        ext_run("ext_off3", 4'b1000);
        for (int r = 0; r < 3; r++) begin
            ext_run($sformatf("ext_rand%0d", r), 4'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
